// File: rtl/focus_adc_frontend_if.sv
// Pin and result bundle of the focus ADC front end: SPI pins toward the ADC plus
// the averaged focus error, strobe and status toward the PID core.
interface focus_adc_frontend_if;
    logic        enable;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_mosi;
    logic        adc_miso;
    logic [15:0] focus_signal;
    logic        focus_valid;
    logic        sat_flag;
    logic        busy;

    modport master (
        input  enable,
        input  adc_miso,
        output adc_cs_n,
        output adc_sclk,
        output adc_mosi,
        output focus_signal,
        output focus_valid,
        output sat_flag,
        output busy
    );

    modport slave (
        output enable,
        output adc_miso,
        input  adc_cs_n,
        input  adc_sclk,
        input  adc_mosi,
        input  focus_signal,
        input  focus_valid,
        input  sat_flag,
        input  busy
    );
endinterface

// File: rtl/focus_adc_frontend.sv
// Focus ADC front end: reads photodiode halves A and B over SPI (mode 0), forms A-B and
// box-car averages 2^AVG_LOG2 differences into a signed 16-bit focus error.
module focus_adc_frontend #(
    parameter int CLK_DIV       = 4,
    parameter int ADC_BITS      = 12,
    parameter int AVG_LOG2      = 2,
    parameter int SAMPLE_PERIOD = 5000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    focus_adc_frontend_if.master bus
);
    localparam int AW  = ADC_BITS + 1 + AVG_LOG2;
    localparam int GW  = $clog2(2 * CLK_DIV);
    localparam int PW  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int SHL = 15 - ADC_BITS;
    localparam logic [GW-1:0]       DIV_MAX = GW'(CLK_DIV - 1);
    localparam logic [GW-1:0]       GAP_MAX = GW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0]       PER_MAX = PW'(SAMPLE_PERIOD - 1);
    localparam logic [6:0]          AVG_N   = 7'(1 << AVG_LOG2);
    localparam logic [ADC_BITS-1:0] FULL    = {ADC_BITS{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONV_A = 3'd1,
        S_GAP    = 3'd2,
        S_CONV_B = 3'd3,
        S_ACCUM  = 3'd4,
        S_WAIT   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         tick_q, tick_d;
    logic [3:0]            bit_q, bit_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [15:0]           tx_q, tx_d;
    logic [15:0]           rx_q, rx_d;
    logic [ADC_BITS-1:0]   a_q, a_d;
    logic [ADC_BITS-1:0]   b_q, b_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [6:0]            cnt_q, cnt_d;
    logic                  win_q, win_d;
    logic [PW-1:0]         per_q, per_d;
    logic [15:0]           focus_q, focus_d;
    logic                  valid_q, valid_d;
    logic                  sat_q, sat_d;
    logic                  busy_q, busy_d;

    logic signed [ADC_BITS:0] diff_s;
    logic signed [AW-1:0]     sum_s;
    logic signed [AW-1:0]     avg_s;
    logic [15:0]              ext_s;
    logic                     start_a_s;
    logic                     unused_s;

    // The MSB of the receive shifter falls off the end; only the low ADC_BITS are kept.
    assign unused_s = rx_q[15];

    // Next-state, SPI frame sequencing and averaging datapath.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        per_d     = per_q;
        focus_d   = focus_q;
        valid_d   = 1'b0;
        sat_d     = sat_q;
        start_a_s = 1'b0;
        diff_s    = $signed({1'b0, a_q}) - $signed({1'b0, b_q});
        sum_s     = acc_q + AW'(diff_s);
        avg_s     = sum_s >>> AVG_LOG2;
        ext_s     = 16'(avg_s);

        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    start_a_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CONV_A, S_CONV_B: begin
                if (tick_q == DIV_MAX) begin
                    tick_d = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_d = {rx_q[14:0], bus.adc_miso};
                    end else if (bit_q == 4'd15) begin
                        // 16th falling edge closes the frame; the last bit was taken on the prior rise.
                        cs_n_d = 1'b1;
                        mosi_d = 1'b0;
                        bit_d  = 4'd0;
                        if (state_q == S_CONV_A) begin
                            a_d     = rx_q[ADC_BITS-1:0];
                            state_d = S_GAP;
                        end else begin
                            b_d     = rx_q[ADC_BITS-1:0];
                            state_d = S_ACCUM;
                        end
                    end else begin
                        bit_d  = bit_q + 4'd1;
                        mosi_d = tx_q[15];
                        tx_d   = {tx_q[14:0], 1'b0};
                    end
                end else begin
                    tick_d = tick_q + GW'(1);
                end
            end
            S_GAP: begin
                if (tick_q == GAP_MAX) begin
                    tick_d  = '0;
                    bit_d   = 4'd0;
                    state_d = S_CONV_B;
                    cs_n_d  = 1'b0;
                    mosi_d  = 1'b1;
                    tx_d    = 16'h8000;
                end else begin
                    tick_d = tick_q + GW'(1);
                end
            end
            S_ACCUM: begin
                acc_d = sum_s;
                win_d = win_q | (a_q == FULL) | (b_q == FULL);
                cnt_d = cnt_q + 7'd1;
                if ((cnt_q + 7'd1) == AVG_N) begin
                    focus_d = ext_s << SHL;
                    sat_d   = win_d;
                    valid_d = 1'b1;
                    acc_d   = '0;
                    cnt_d   = 7'd0;
                    win_d   = 1'b0;
                end else begin
                    valid_d = 1'b0;
                end
                if (!bus.enable) begin
                    // A disable drops the partial window so the next run starts clean.
                    state_d = S_IDLE;
                    acc_d   = '0;
                    cnt_d   = 7'd0;
                    win_d   = 1'b0;
                end else if (per_q == PER_MAX) begin
                    start_a_s = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    cnt_d   = 7'd0;
                    win_d   = 1'b0;
                end else if (per_q == PER_MAX) begin
                    start_a_s = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase

        // Period counter restarts with each A frame and parks at its terminal count.
        if (start_a_s) begin
            state_d = S_CONV_A;
            per_d   = '0;
            tick_d  = '0;
            bit_d   = 4'd0;
            cs_n_d  = 1'b0;
            sclk_d  = 1'b0;
            mosi_d  = 1'b1;
            tx_d    = 16'h0000;
        end else if (per_q != PER_MAX) begin
            per_d = per_q + PW'(1);
        end else begin
            per_d = per_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= 4'd0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            tx_q    <= 16'h0000;
            rx_q    <= 16'h0000;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= 7'd0;
            win_q   <= 1'b0;
            per_q   <= '0;
            focus_q <= 16'h0000;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            per_q   <= per_d;
            focus_q <= focus_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.adc_cs_n     = cs_n_q;
    assign bus.adc_sclk     = sclk_q;
    assign bus.adc_mosi     = mosi_q;
    assign bus.focus_signal = focus_q;
    assign bus.focus_valid  = valid_q;
    assign bus.sat_flag     = sat_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_focus_adc_frontend.sv
// Bench for focus_adc_frontend: SPI ADC model serving a directed pair table, with a
// scoreboard of hand-computed averaged results popped by an independent monitor.
module tb_focus_adc_frontend;
    localparam int SP = 1000;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    focus_adc_frontend_if bus();

    focus_adc_frontend #(
        .CLK_DIV(4), .ADC_BITS(12), .AVG_LOG2(2), .SAMPLE_PERIOD(SP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    typedef struct {
        logic [15:0] sig;
        logic        sat;
        int          pairs;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Directed A/B values per conversion pair, {A, B}.
    function automatic logic [23:0] pair_data(input int i);
        if (i == 0)       return {12'h800, 12'h600};
        else if (i < 4)   return {12'h900, 12'h700};
        else if (i < 7)   return {12'h000, 12'h001};
        else if (i == 7)  return {12'h555, 12'h555};
        else if (i == 8)  return {12'h100, 12'hFFF};
        else if (i < 12)  return {12'h200, 12'h100};
        else if (i < 16)  return {12'hFFE, 12'h000};
        else if (i < 20)  return {12'h000, 12'hFFF};
        else if (i == 20) return {12'hFFF, 12'h000};
        else              return {12'h300, 12'h100};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model state
    logic        prev_cs    = 1'b1;
    logic        prev_sclk  = 1'b0;
    logic        chan_b     = 1'b0;
    int          pair_idx   = 0;
    logic [15:0] tx_word    = 16'h0000;
    logic [15:0] rx_word    = 16'h0000;
    logic [23:0] pd;
    int          rises      = 0;
    int          last_rise  = 0;
    int          cs_rise_cyc = 0;
    int          last_a_start = 0;
    bit          a_start_ok = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            chan_b     = 1'b0;
            a_start_ok = 1'b0;
            rises      = 0;
            bus.adc_miso = 1'b0;
        end else begin
            if (prev_cs && !bus.adc_cs_n) begin
                if (chan_b) begin
                    check("gap_len", cyc - cs_rise_cyc, 8);
                end else begin
                    if (a_start_ok) check("pair_spacing", cyc - last_a_start, SP);
                    last_a_start = cyc;
                    a_start_ok   = 1'b1;
                end
                pd = pair_data(pair_idx);
                tx_word = {4'hA, chan_b ? pd[11:0] : pd[23:12]};
                bus.adc_miso = tx_word[15];
                rises   = 0;
                rx_word = 16'h0000;
            end
            if (!bus.adc_cs_n && !prev_sclk && bus.adc_sclk) begin
                if (rises > 0) check("sclk_period", cyc - last_rise, 8);
                last_rise = cyc;
                rises++;
                rx_word = {rx_word[14:0], bus.adc_mosi};
            end
            if (!bus.adc_cs_n && prev_sclk && !bus.adc_sclk) begin
                tx_word = {tx_word[14:0], 1'b0};
                bus.adc_miso = tx_word[15];
            end
            if (!prev_cs && bus.adc_cs_n) begin
                check("sclk_rises", rises, 16);
                check(chan_b ? "cmd_b" : "cmd_a", rx_word, chan_b ? 16'hC000 : 16'h8000);
                cs_rise_cyc = cyc;
                if (chan_b) pair_idx++;
                chan_b = ~chan_b;
            end
            if (!bus.busy) a_start_ok = 1'b0;
        end
        prev_cs   = bus.adc_cs_n;
        prev_sclk = bus.adc_sclk;
    end

    // Monitor: every valid strobe must match the oldest scoreboard entry.
    logic prev_valid = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (reset_n && bus.focus_valid) begin
            check("valid_width", prev_valid, 1'b0);
            check("sb_nonempty", sb_q.size() > 0, 1'b1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("focus_signal", bus.focus_signal, e.sig);
                check("sat_flag", bus.sat_flag, e.sat);
                check("valid_pair_count", pair_idx, e.pairs);
            end
        end
        prev_valid = bus.focus_valid;
    end

    task automatic wait_sb_empty(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        bit found;
        reset_n    = 1'b0;
        bus.enable = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", bus.adc_cs_n, 1'b1);
        check("rst_sclk", bus.adc_sclk, 1'b0);
        check("rst_mosi", bus.adc_mosi, 1'b0);
        check("rst_focus", bus.focus_signal, 16'h0000);
        check("rst_valid", bus.focus_valid, 1'b0);
        check("rst_sat", bus.sat_flag, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        reset_n = 1'b1;

        sb_q.push_back('{16'h1000, 1'b0, 4});
        sb_q.push_back('{16'hFFF8, 1'b0, 8});
        sb_q.push_back('{16'hE800, 1'b1, 12});
        sb_q.push_back('{16'h7FF0, 1'b0, 16});
        sb_q.push_back('{16'h8008, 1'b1, 20});
        bus.enable = 1'b1;
        wait_sb_empty(22000);

        // Disable while channel B of the next pair is converting.
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            found = chan_b && !bus.adc_cs_n;
        end
        check("reach_conv_b", found, 1'b1);
        repeat (20) @(negedge clk);
        bus.enable = 1'b0;
        for (int i = 0; i < 400 && bus.busy; i++) @(negedge clk);
        check("idle_after_disable", bus.busy, 1'b0);
        check("pair_completed", pair_idx, 21);
        check("focus_held", bus.focus_signal, 16'h8008);
        check("sat_held", bus.sat_flag, 1'b1);
        repeat (50) @(negedge clk);
        check("stays_idle_busy", bus.busy, 1'b0);
        check("stays_idle_cs", bus.adc_cs_n, 1'b1);

        // Re-enable, then reset in the middle of the A frame.
        bus.enable = 1'b1;
        for (int i = 0; i < 10 && bus.adc_cs_n; i++) @(negedge clk);
        check("restart_cs_low", bus.adc_cs_n, 1'b0);
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midframe_rst_cs_n", bus.adc_cs_n, 1'b1);
        check("midframe_rst_sclk", bus.adc_sclk, 1'b0);
        check("midframe_rst_busy", bus.busy, 1'b0);
        check("midframe_rst_focus", bus.focus_signal, 16'h0000);
        check("midframe_rst_sat", bus.sat_flag, 1'b0);
        repeat (2) @(negedge clk);
        sb_q.push_back('{16'h1000, 1'b0, 25});
        reset_n = 1'b1;
        wait_sb_empty(6000);
        repeat (100) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
